// File: rtl/flash_seq_pkg.sv
// -----------------------------------------------------------------------------
// flash_seq_pkg
// Shared types and constants for the parallel-flash command sequencer.
//   - cmd_op_e     : command opcodes presented on CmdOp
//   - seq_state_e  : top-level sequencer states
//   - bus_phase_e  : phases of a single flash bus cycle
//   - addr_sel_e / data_sel_e : address/data sources for one sequence step
//   - step_t       : one entry of the per-op step ROM
//   - step_rom()   : returns the step descriptor for (op, step index)
// -----------------------------------------------------------------------------
package flash_seq_pkg;

    typedef enum logic [2:0] {
        OP_READ         = 3'd0,
        OP_PROGRAM      = 3'd1,
        OP_SECTOR_ERASE = 3'd2,
        OP_CHIP_ERASE   = 3'd3,
        OP_READ_ID      = 3'd4
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_PULSE = 2'd2,
        PH_HOLD  = 2'd3
    } bus_phase_e;

    typedef enum logic [2:0] {
        A_5555 = 3'd0,
        A_2AAA = 3'd1,
        A_CMD  = 3'd2,
        A_0000 = 3'd3,
        A_0001 = 3'd4
    } addr_sel_e;

    typedef enum logic [3:0] {
        D_AA  = 4'd0,
        D_55  = 4'd1,
        D_A0  = 4'd2,
        D_80  = 4'd3,
        D_30  = 4'd4,
        D_10  = 4'd5,
        D_90  = 4'd6,
        D_F0  = 4'd7,
        D_CMD = 4'd8
    } data_sel_e;

    typedef struct packed {
        logic      is_read;
        addr_sel_e addr_sel;
        data_sel_e data_sel;
        logic      last;
    } step_t;

    // JEDEC unlock addresses and command bytes
    localparam logic [15:0] CMD_ADDR_5555 = 16'h5555;
    localparam logic [15:0] CMD_ADDR_2AAA = 16'h2AAA;
    localparam logic [7:0]  CMD_AA        = 8'hAA;
    localparam logic [7:0]  CMD_55        = 8'h55;
    localparam logic [7:0]  CMD_A0        = 8'hA0;
    localparam logic [7:0]  CMD_80        = 8'h80;
    localparam logic [7:0]  CMD_30        = 8'h30;
    localparam logic [7:0]  CMD_10        = 8'h10;
    localparam logic [7:0]  CMD_90        = 8'h90;
    localparam logic [7:0]  CMD_F0        = 8'hF0;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

    // Program and both erases finish with toggle-bit polling
    function automatic logic op_polls(input logic [2:0] op);
        return (op == 3'(OP_PROGRAM)) || (op == 3'(OP_SECTOR_ERASE)) ||
               (op == 3'(OP_CHIP_ERASE));
    endfunction

    function automatic step_t wr_step(input addr_sel_e a, input data_sel_e d,
                                      input logic last);
        step_t s;
        s.is_read  = 1'b0;
        s.addr_sel = a;
        s.data_sel = d;
        s.last     = last;
        return s;
    endfunction

    function automatic step_t rd_step(input addr_sel_e a, input logic last);
        step_t s;
        s.is_read  = 1'b1;
        s.addr_sel = a;
        s.data_sel = D_CMD;
        s.last     = last;
        return s;
    endfunction

    function automatic step_t step_rom(input logic [2:0] op, input logic [2:0] idx);
        step_t s;
        s = rd_step(A_CMD, 1'b1);
        case (cmd_op_e'(op))
            OP_READ: s = rd_step(A_CMD, 1'b1);
            OP_PROGRAM: begin
                case (idx)
                    3'd0:    s = wr_step(A_5555, D_AA, 1'b0);
                    3'd1:    s = wr_step(A_2AAA, D_55, 1'b0);
                    3'd2:    s = wr_step(A_5555, D_A0, 1'b0);
                    default: s = wr_step(A_CMD, D_CMD, 1'b1);
                endcase
            end
            OP_SECTOR_ERASE, OP_CHIP_ERASE: begin
                case (idx)
                    3'd0:    s = wr_step(A_5555, D_AA, 1'b0);
                    3'd1:    s = wr_step(A_2AAA, D_55, 1'b0);
                    3'd2:    s = wr_step(A_5555, D_80, 1'b0);
                    3'd3:    s = wr_step(A_5555, D_AA, 1'b0);
                    3'd4:    s = wr_step(A_2AAA, D_55, 1'b0);
                    default: s = (op == 3'(OP_SECTOR_ERASE)) ?
                                 wr_step(A_CMD, D_30, 1'b1) :
                                 wr_step(A_5555, D_10, 1'b1);
                endcase
            end
            OP_READ_ID: begin
                case (idx)
                    3'd0:    s = wr_step(A_5555, D_AA, 1'b0);
                    3'd1:    s = wr_step(A_2AAA, D_55, 1'b0);
                    3'd2:    s = wr_step(A_5555, D_90, 1'b0);
                    3'd3:    s = rd_step(A_0000, 1'b0);
                    3'd4:    s = rd_step(A_0001, 1'b0);
                    default: s = wr_step(A_5555, D_F0, 1'b1);
                endcase
            end
            default: s = rd_step(A_CMD, 1'b1);
        endcase
        return s;
    endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// -----------------------------------------------------------------------------
// flash_bus_cycle
// Timer for one flash bus cycle: SETUP (1 cycle), PULSE (WE_PULSE or RD_PULSE
// cycles with the strobe low), HOLD (1 cycle). A start seen in IDLE or HOLD
// begins a new cycle on the next clock, so steps can run back to back.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        begin a cycle (only honoured in IDLE or HOLD)
//   i_is_read      cycle type, captured with i_start
//   o_webar        write strobe, active low
//   o_rebar        output enable strobe, active low
//   o_sample       high on the last PULSE cycle of a read (capture DQ)
//   o_cyc_done     high during HOLD, the final cycle of the bus cycle
// -----------------------------------------------------------------------------
module flash_bus_cycle
    import flash_seq_pkg::*;
#(
    parameter int WE_PULSE = 2,
    parameter int RD_PULSE = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_is_read,
    output logic o_webar,
    output logic o_rebar,
    output logic o_sample,
    output logic o_cyc_done
);

    localparam int MAX_PULSE = (WE_PULSE > RD_PULSE) ? WE_PULSE : RD_PULSE;
    localparam int CNT_W     = (MAX_PULSE < 2) ? 1 : $clog2(MAX_PULSE + 1);

    bus_phase_e       r_phase;
    bus_phase_e       w_phase_n;
    logic             r_is_read;
    logic             w_is_read_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_last_pulse;

    assign w_last_pulse = r_is_read ? (r_cnt == CNT_W'(RD_PULSE - 1))
                                    : (r_cnt == CNT_W'(WE_PULSE - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase   <= PH_IDLE;
            r_is_read <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_phase   <= w_phase_n;
            r_is_read <= w_is_read_n;
            r_cnt     <= w_cnt_n;
        end
    end

    always_comb begin
        w_phase_n   = r_phase;
        w_is_read_n = r_is_read;
        w_cnt_n     = r_cnt;
        case (r_phase)
            PH_IDLE: begin
                if (i_start) begin
                    w_phase_n   = PH_SETUP;
                    w_is_read_n = i_is_read;
                end
            end
            PH_SETUP: begin
                w_phase_n = PH_PULSE;
                w_cnt_n   = '0;
            end
            PH_PULSE: begin
                if (w_last_pulse) begin
                    w_phase_n = PH_HOLD;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            PH_HOLD: begin
                if (i_start) begin
                    w_phase_n   = PH_SETUP;
                    w_is_read_n = i_is_read;
                end else begin
                    w_phase_n = PH_IDLE;
                end
            end
            default: w_phase_n = PH_IDLE;
        endcase
    end

    assign o_webar    = !((r_phase == PH_PULSE) && !r_is_read);
    assign o_rebar    = !((r_phase == PH_PULSE) && r_is_read);
    assign o_sample   = (r_phase == PH_PULSE) && r_is_read && w_last_pulse;
    assign o_cyc_done = (r_phase == PH_HOLD);

endmodule

// File: rtl/flash_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// flash_cmd_sequencer
// Expands a command (read, program, sector/chip erase, read-ID) into the JEDEC
// software-command bus sequence for a parallel flash, then polls DQ6 toggle
// bit for program/erase completion with a bounded number of poll pairs.
// Ports:
//   SCL, RST            clock (rising edge), synchronous active-high reset
//   CmdValid/CmdReady   command handshake; ready only in IDLE
//   CmdOp/CmdAddr/CmdData  command, target address, program data
//   Done                one-cycle pulse at the end of every accepted command
//   Error               timeout or illegal op; held until the next accept
//   RdData              READ: {8'h00,byte}; READ_ID: {device,manufacturer}
//   FAddr/FDataOut/FDataOE/FDataIn  flash address and data bus
//   ENbar/WEbar/REbar   flash strobes, active low
// -----------------------------------------------------------------------------
module flash_cmd_sequencer
    import flash_seq_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int WE_PULSE = 2,
    parameter int RD_PULSE = 2,
    parameter int POLL_MAX = 1023
) (
    input  logic              SCL,
    input  logic              RST,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [2:0]        CmdOp,
    input  logic [ADDR_W-1:0] CmdAddr,
    input  logic [7:0]        CmdData,
    output logic              Done,
    output logic              Error,
    output logic [15:0]       RdData,
    output logic [ADDR_W-1:0] FAddr,
    output logic [7:0]        FDataOut,
    output logic              FDataOE,
    input  logic [7:0]        FDataIn,
    output logic              ENbar,
    output logic              WEbar,
    output logic              REbar
);

    localparam int CNT_W = $clog2(POLL_MAX + 1);

    seq_state_e        r_state,    w_state_n;
    logic [2:0]        r_op,       w_op_n;
    logic [ADDR_W-1:0] r_addr,     w_addr_n;
    logic [7:0]        r_data,     w_data_n;
    logic [2:0]        r_step,     w_step_n;
    logic              r_last,     w_last_n;
    logic              r_rd_hi,    w_rd_hi_n;
    logic              r_polling,  w_polling_n;
    logic              r_second,   w_second_n;
    logic              r_dq6,      w_dq6_n;
    logic              r_dq6_eq,   w_dq6_eq_n;
    logic [CNT_W-1:0]  r_poll_cnt, w_poll_cnt_n;
    logic              r_error,    w_error_n;
    logic [15:0]       r_rddata,   w_rddata_n;
    logic [ADDR_W-1:0] r_faddr,    w_faddr_n;
    logic [7:0]        r_fdout,    w_fdout_n;
    logic              r_fdoe,     w_fdoe_n;

    logic              w_start;
    logic              w_start_read;
    logic              w_sample;
    logic              w_cyc_done;
    logic              w_launch_step;
    logic              w_launch_poll;
    logic [2:0]        w_rom_op;
    logic [2:0]        w_rom_idx;
    step_t             w_nxt;
    logic [ADDR_W-1:0] w_base_addr;
    logic [7:0]        w_base_data;
    logic [CNT_W-1:0]  w_poll_cnt_inc;

    function automatic logic [ADDR_W-1:0] sel_addr(input addr_sel_e a,
                                                   input logic [ADDR_W-1:0] base);
        case (a)
            A_5555:  return ADDR_W'(CMD_ADDR_5555);
            A_2AAA:  return ADDR_W'(CMD_ADDR_2AAA);
            A_0000:  return '0;
            A_0001:  return ADDR_W'(1);
            default: return base;
        endcase
    endfunction

    function automatic logic [7:0] sel_data(input data_sel_e d, input logic [7:0] base);
        case (d)
            D_AA:    return CMD_AA;
            D_55:    return CMD_55;
            D_A0:    return CMD_A0;
            D_80:    return CMD_80;
            D_30:    return CMD_30;
            D_10:    return CMD_10;
            D_90:    return CMD_90;
            D_F0:    return CMD_F0;
            default: return base;
        endcase
    endfunction

    flash_bus_cycle #(
        .WE_PULSE (WE_PULSE),
        .RD_PULSE (RD_PULSE)
    ) u_bus (
        .i_clk      (SCL),
        .i_rst      (RST),
        .i_start    (w_start),
        .i_is_read  (w_start_read),
        .o_webar    (WEbar),
        .o_rebar    (REbar),
        .o_sample   (w_sample),
        .o_cyc_done (w_cyc_done)
    );

    // In IDLE the first step comes straight from the command inputs so the
    // bus cycle's SETUP lands on the cycle right after the accept.
    assign w_rom_op       = (r_state == S_IDLE) ? CmdOp   : r_op;
    assign w_rom_idx      = (r_state == S_IDLE) ? 3'd0    : (r_step + 3'd1);
    assign w_base_addr    = (r_state == S_IDLE) ? CmdAddr : r_addr;
    assign w_base_data    = (r_state == S_IDLE) ? CmdData : r_data;
    assign w_nxt          = step_rom(w_rom_op, w_rom_idx);
    assign w_poll_cnt_inc = r_poll_cnt + 1'b1;

    always_ff @(posedge SCL) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_step     <= '0;
            r_last     <= 1'b0;
            r_rd_hi    <= 1'b0;
            r_polling  <= 1'b0;
            r_second   <= 1'b0;
            r_dq6      <= 1'b0;
            r_dq6_eq   <= 1'b0;
            r_poll_cnt <= '0;
            r_error    <= 1'b0;
            r_rddata   <= '0;
            r_faddr    <= '0;
            r_fdout    <= '0;
            r_fdoe     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_op       <= w_op_n;
            r_addr     <= w_addr_n;
            r_data     <= w_data_n;
            r_step     <= w_step_n;
            r_last     <= w_last_n;
            r_rd_hi    <= w_rd_hi_n;
            r_polling  <= w_polling_n;
            r_second   <= w_second_n;
            r_dq6      <= w_dq6_n;
            r_dq6_eq   <= w_dq6_eq_n;
            r_poll_cnt <= w_poll_cnt_n;
            r_error    <= w_error_n;
            r_rddata   <= w_rddata_n;
            r_faddr    <= w_faddr_n;
            r_fdout    <= w_fdout_n;
            r_fdoe     <= w_fdoe_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_op_n        = r_op;
        w_addr_n      = r_addr;
        w_data_n      = r_data;
        w_step_n      = r_step;
        w_last_n      = r_last;
        w_rd_hi_n     = r_rd_hi;
        w_polling_n   = r_polling;
        w_second_n    = r_second;
        w_dq6_n       = r_dq6;
        w_dq6_eq_n    = r_dq6_eq;
        w_poll_cnt_n  = r_poll_cnt;
        w_error_n     = r_error;
        w_rddata_n    = r_rddata;
        w_faddr_n     = r_faddr;
        w_fdout_n     = r_fdout;
        w_fdoe_n      = r_fdoe;
        w_start       = 1'b0;
        w_start_read  = 1'b0;
        w_launch_step = 1'b0;
        w_launch_poll = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (CmdValid) begin
                    w_op_n       = CmdOp;
                    w_addr_n     = CmdAddr;
                    w_data_n     = CmdData;
                    w_step_n     = 3'd0;
                    w_polling_n  = 1'b0;
                    w_second_n   = 1'b0;
                    w_poll_cnt_n = '0;
                    w_error_n    = 1'b0;
                    if (op_legal(CmdOp)) begin
                        w_state_n     = S_RUN;
                        w_launch_step = 1'b1;
                    end else begin
                        // Illegal op: no bus activity, straight to DONE
                        w_state_n = S_DONE;
                        w_error_n = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_sample) begin
                    if (r_polling) begin
                        if (!r_second) begin
                            w_dq6_n = FDataIn[6];
                        end else begin
                            w_dq6_eq_n = (FDataIn[6] == r_dq6);
                        end
                    end else if (r_op == 3'(OP_READ)) begin
                        w_rddata_n = {8'h00, FDataIn};
                    end else if (r_rd_hi) begin
                        w_rddata_n[15:8] = FDataIn;
                    end else begin
                        w_rddata_n[7:0] = FDataIn;
                    end
                end
                if (w_cyc_done) begin
                    if (r_polling) begin
                        if (!r_second) begin
                            w_second_n    = 1'b1;
                            w_launch_poll = 1'b1;
                        end else if (r_dq6_eq) begin
                            // DQ6 stopped toggling: operation complete
                            w_state_n = S_DONE;
                        end else if (w_poll_cnt_inc == CNT_W'(POLL_MAX)) begin
                            w_error_n = 1'b1;
                            w_state_n = S_DONE;
                        end else begin
                            w_poll_cnt_n  = w_poll_cnt_inc;
                            w_second_n    = 1'b0;
                            w_launch_poll = 1'b1;
                        end
                    end else if (r_last) begin
                        if (op_polls(r_op)) begin
                            w_polling_n   = 1'b1;
                            w_second_n    = 1'b0;
                            w_poll_cnt_n  = '0;
                            w_launch_poll = 1'b1;
                        end else begin
                            w_state_n = S_DONE;
                        end
                    end else begin
                        w_step_n      = r_step + 3'd1;
                        w_launch_step = 1'b1;
                    end
                end
            end
            S_DONE: w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase

        // Address/data/OE are registered at launch so they are stable from
        // SETUP through HOLD of the bus cycle.
        if (w_launch_step) begin
            w_start      = 1'b1;
            w_start_read = w_nxt.is_read;
            w_faddr_n    = sel_addr(w_nxt.addr_sel, w_base_addr);
            w_fdoe_n     = !w_nxt.is_read;
            if (!w_nxt.is_read) begin
                w_fdout_n = sel_data(w_nxt.data_sel, w_base_data);
            end
            w_last_n  = w_nxt.last;
            w_rd_hi_n = (w_nxt.addr_sel == A_0001);
        end else if (w_launch_poll) begin
            w_start      = 1'b1;
            w_start_read = 1'b1;
            w_faddr_n    = r_addr;
            w_fdoe_n     = 1'b0;
        end
        if (w_state_n == S_DONE) begin
            w_fdoe_n = 1'b0;
        end
    end

    assign CmdReady = (r_state == S_IDLE);
    assign Done     = (r_state == S_DONE);
    assign Error    = r_error;
    assign RdData   = r_rddata;
    assign FAddr    = r_faddr;
    assign FDataOut = r_fdout;
    assign FDataOE  = r_fdoe;
    assign ENbar    = (r_state != S_RUN);

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
module tb_flash_cmd_sequencer;

    logic        SCL = 1'b0;
    logic        RST;
    logic        CmdValid;
    logic        CmdReady;
    logic [2:0]  CmdOp;
    logic [15:0] CmdAddr;
    logic [7:0]  CmdData;
    logic        Done;
    logic        Error;
    logic [15:0] RdData;
    logic [15:0] FAddr;
    logic [7:0]  FDataOut;
    logic        FDataOE;
    logic [7:0]  FDataIn;
    logic        ENbar;
    logic        WEbar;
    logic        REbar;

    flash_cmd_sequencer #(
        .ADDR_W   (16),
        .WE_PULSE (2),
        .RD_PULSE (2),
        .POLL_MAX (4)
    ) dut (
        .SCL      (SCL),
        .RST      (RST),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .CmdOp    (CmdOp),
        .CmdAddr  (CmdAddr),
        .CmdData  (CmdData),
        .Done     (Done),
        .Error    (Error),
        .RdData   (RdData),
        .FAddr    (FAddr),
        .FDataOut (FDataOut),
        .FDataOE  (FDataOE),
        .FDataIn  (FDataIn),
        .ENbar    (ENbar),
        .WEbar    (WEbar),
        .REbar    (REbar)
    );

    always #5 SCL = ~SCL;

    int n_checks = 0;
    int n_pass   = 0;

    // Flash model: fixed bytes at known addresses, toggle bit elsewhere.
    logic dq6         = 1'b0;
    logic tog_en      = 1'b0;
    logic tog_forever = 1'b0;
    int   tog_cnt     = 0;
    int   tog_limit   = 0;

    always_comb begin
        case (FAddr)
            16'h1234: FDataIn = 8'h5A;
            16'h0000: FDataIn = 8'hBF;
            16'h0001: FDataIn = 8'hD7;
            default:  FDataIn = {1'b0, dq6, 6'h15};
        endcase
    end

    always @(posedge REbar) begin
        if (tog_en && (tog_forever || tog_cnt < tog_limit)) begin
            dq6 = ~dq6;
            tog_cnt++;
        end
    end

    // Bus monitor: records each write {addr,data,low-cycles} and read {addr,low-cycles}
    logic [31:0] wq[$];
    logic [23:0] rq[$];
    int we_cnt = 0;
    int re_cnt = 0;
    int oe_conflict = 0;
    int en_cycles = 0;

    always @(negedge SCL) begin
        if (!WEbar) begin
            we_cnt++;
        end else if (we_cnt != 0) begin
            wq.push_back({FAddr, FDataOut, 8'(we_cnt)});
            we_cnt = 0;
        end
        if (!REbar) begin
            re_cnt++;
            if (FDataOE) oe_conflict++;
        end else if (re_cnt != 0) begin
            rq.push_back({FAddr, 8'(re_cnt)});
            re_cnt = 0;
        end
        if (!ENbar) en_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issue one command; lat = cycles from the accept cycle to the Done cycle.
    task automatic run_cmd(input logic [2:0] op, input logic [15:0] addr,
                           input logic [7:0] data, output int lat);
        @(negedge SCL);
        wq.delete();
        rq.delete();
        oe_conflict = 0;
        en_cycles   = 0;
        CmdOp    = op;
        CmdAddr  = addr;
        CmdData  = data;
        CmdValid = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge SCL);
            lat++;
            if (lat == 1) CmdValid = 1'b0;
            if (Done) break;
            if (lat > 2000) begin
                check("done_timeout", 32'(lat), 32'd0);
                break;
            end
        end
    endtask

    function automatic logic [31:0] wrec(input int i);
        return (wq.size() > i) ? wq[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [23:0] rrec(input int i);
        return (rq.size() > i) ? rq[i] : 24'hDEAD_BE;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] exp_prog [4];
    logic [31:0] exp_se   [6];

    initial begin
        int lat;
        int bound;

        RST = 1'b1; CmdValid = 1'b0; CmdOp = '0; CmdAddr = '0; CmdData = '0;
        repeat (3) @(negedge SCL);

        // Reset state
        check("rst_ready", CmdReady, 1);
        check("rst_done_err", {Done, Error}, 2'b00);
        check("rst_strobes", {ENbar, WEbar, REbar, FDataOE}, 4'b1110);
        check("rst_rddata", RdData, 16'h0000);
        check("rst_addr_data", {FAddr, FDataOut}, 24'h0);
        RST = 1'b0;

        // Plain READ
        run_cmd(3'd0, 16'h1234, 8'h00, lat);
        check("read_lat", lat, 5);
        check("read_data", RdData, 16'h005A);
        check("read_err", Error, 0);
        check("read_nrd", rq.size(), 1);
        check("read_cyc", rrec(0), {16'h1234, 8'd2});
        check("read_nwr", wq.size(), 0);
        check("read_oe", oe_conflict, 0);
        @(negedge SCL);
        check("read_done_pulse", {Done, CmdReady}, 2'b01);

        // PROGRAM with DQ6 toggling on the first 3 poll reads
        tog_en = 1'b1; tog_forever = 1'b0; tog_limit = tog_cnt + 3;
        exp_prog = '{{16'h5555, 8'hAA, 8'd2}, {16'h2AAA, 8'h55, 8'd2},
                     {16'h5555, 8'hA0, 8'd2}, {16'h0100, 8'h3C, 8'd2}};
        run_cmd(3'd1, 16'h0100, 8'h3C, lat);
        check("prog_nwr", wq.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("prog_w%0d", i), wrec(i), exp_prog[i]);
        check("prog_nrd", rq.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("prog_r%0d", i), rrec(i), {16'h0100, 8'd2});
        check("prog_lat", lat, 41);
        check("prog_err", Error, 0);
        check("prog_oe", oe_conflict, 0);

        // SECTOR_ERASE with DQ6 toggling forever: 4 poll pairs then timeout
        tog_forever = 1'b1;
        exp_se = '{{16'h5555, 8'hAA, 8'd2}, {16'h2AAA, 8'h55, 8'd2},
                   {16'h5555, 8'h80, 8'd2}, {16'h5555, 8'hAA, 8'd2},
                   {16'h2AAA, 8'h55, 8'd2}, {16'h2000, 8'h30, 8'd2}};
        run_cmd(3'd2, 16'h2000, 8'h00, lat);
        check("se_nwr", wq.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("se_w%0d", i), wrec(i), exp_se[i]);
        check("se_nrd", rq.size(), 8);
        check("se_lat", lat, 57);
        check("se_err", Error, 1);
        tog_en = 1'b0; tog_forever = 1'b0;

        // READ_ID
        run_cmd(3'd4, 16'h0000, 8'h00, lat);
        check("id_data", RdData, 16'hD7BF);
        check("id_err", Error, 0);
        check("id_nwr", wq.size(), 4);
        check("id_w2", wrec(2), {16'h5555, 8'h90, 8'd2});
        check("id_w3", wrec(3), {16'h5555, 8'hF0, 8'd2});
        check("id_r0", rrec(0), {16'h0000, 8'd2});
        check("id_r1", rrec(1), {16'h0001, 8'd2});
        check("id_oe", oe_conflict, 0);
        check("id_lat", lat, 25);

        // Reset during the second write of CHIP_ERASE
        @(negedge SCL);
        wq.delete();
        CmdOp = 3'd3; CmdAddr = 16'h0000; CmdData = 8'h00; CmdValid = 1'b1;
        @(negedge SCL);
        CmdValid = 1'b0;
        bound = 0;
        while (!(wq.size() == 1 && !WEbar) && bound < 100) begin
            @(negedge SCL);
            bound++;
        end
        check("ce_reached_w2", {wrec(0), WEbar}, {16'h5555, 8'hAA, 8'd2, 1'b0});
        RST = 1'b1;
        @(negedge SCL);
        check("ce_rst_strobes", {ENbar, WEbar, REbar, FDataOE}, 4'b1110);
        check("ce_rst_ready", {CmdReady, Done, Error}, 3'b100);
        check("ce_rst_rddata", RdData, 16'h0000);
        check("ce_rst_faddr", FAddr, 16'h0000);
        RST = 1'b0;
        run_cmd(3'd0, 16'h1234, 8'h00, lat);
        check("post_rst_lat", lat, 5);
        check("post_rst_data", RdData, 16'h005A);

        // Illegal op, CmdValid held: second command accepted right after Done
        @(negedge SCL);
        en_cycles = 0;
        CmdOp = 3'd6; CmdAddr = 16'h1234; CmdData = 8'h00; CmdValid = 1'b1;
        @(negedge SCL);
        check("ill_done_err", {Done, Error}, 2'b11);
        CmdOp = 3'd0;
        @(negedge SCL);
        check("b2b_ready", {CmdReady, Done}, 2'b10);
        check("ill_no_en", en_cycles, 0);
        @(negedge SCL);
        CmdValid = 1'b0;
        check("b2b_en", ENbar, 0);
        check("b2b_err_clr", Error, 0);
        lat = 3;
        while (!Done && lat < 200) begin
            @(negedge SCL);
            lat++;
        end
        check("b2b_done_cyc", lat, 7);
        check("b2b_data", RdData, 16'h005A);

        @(negedge SCL);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flash_cmd_sequencer.md
Name: flash_cmd_sequencer

Overview:
- Issues complete JEDEC software-command sequences to the parallel flash on behalf of the I2C Controller.
- Sequences covered: byte program, sector erase, chip erase, read-ID and plain read.
- Each sequence is expanded into individually timed ENbar/WEbar/REbar bus cycles.
- Completion of program and erase is detected by DQ6 toggle-bit polling, with a timeout.
- Sits between the Controller/datapath (command side) and the flash pins.

Parameters:
ADDR_W, 16, flash address width
WE_PULSE, 2, cycles WEbar held low per write cycle (>=1)
RD_PULSE, 2, cycles REbar held low per read cycle (>=1)
POLL_MAX, 1023, max toggle-bit poll pairs before timeout

Ports:
SCL  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
CmdValid  in  1  command request
CmdReady  out  1  high in IDLE only; accept = CmdValid&CmdReady
CmdOp  in  3  0 READ, 1 PROGRAM, 2 SECTOR_ERASE, 3 CHIP_ERASE, 4 READ_ID, 5-7 illegal
CmdAddr  in  ADDR_W  target/sector address
CmdData  in  8  program data
Done  out  1  one-cycle pulse at end of every accepted command
Error  out  1  valid with Done: timeout or illegal op; held until next accept
RdData  out  16  READ: {8'h00,byte}; READ_ID: {device,manufacturer}
FAddr  out  ADDR_W  flash address
FDataOut  out  8  flash write data
FDataOE  out  1  drive FDataOut onto DQ
FDataIn  in  8  flash DQ
ENbar  out  1  chip enable, active low
WEbar  out  1  write enable, active low
REbar  out  1  output enable, active low

Behaviour:
- Reset values: CmdReady=1, Done=0, Error=0, RdData=0, FAddr=0, FDataOut=0, FDataOE=0, ENbar=1, WEbar=1, REbar=1. State IDLE, step=0.
- Accept latches CmdOp/CmdAddr/CmdData. Inputs are ignored while busy.
- Write cycle, 2+WE_PULSE cycles:
  - SETUP: FAddr/FDataOut valid, FDataOE=1, ENbar=0.
  - PULSE: WEbar=0 for WE_PULSE cycles.
  - HOLD: WEbar=1; addr/data held.
- Read cycle, 2+RD_PULSE cycles:
  - SETUP: ENbar=0, FDataOE=0.
  - PULSE: REbar=0; FDataIn is sampled on the last PULSE cycle.
  - HOLD: REbar=1.
- ENbar returns to 1 only in IDLE/DONE. FDataOE and REbar are never both active.
- Sequences (W=write addr/data, R=read):
  - READ: R CmdAddr.
  - PROGRAM: W 5555/AA, W 2AAA/55, W 5555/A0, W CmdAddr/CmdData, POLL.
  - SECTOR_ERASE: W 5555/AA, 2AAA/55, 5555/80, 5555/AA, 2AAA/55, CmdAddr/30, POLL.
  - CHIP_ERASE: same as SECTOR_ERASE but final W 5555/10, POLL.
  - READ_ID: W 5555/AA, 2AAA/55, 5555/90, R 0000 (mfr), R 0001 (dev), W 5555/F0.
- Addresses 5555/2AAA are zero-extended or truncated to ADDR_W.
- POLL: read CmdAddr twice.
  - DQ6 equal in both reads -> DONE.
  - Otherwise increment poll counter and repeat.
  - Counter reaching POLL_MAX -> Error=1, then DONE.
- State machine:
  - IDLE -(accept)-> SETUP
  - SETUP -> PULSE -> HOLD
  - HOLD -> SETUP (next step) | POLL reads | DONE
  - DONE (1 cycle, Done=1) -> IDLE
- Illegal CmdOp: no bus activity; DONE on the cycle after accept with Error=1.
- RST mid-operation: next edge forces IDLE with all outputs at reset values, including RdData and Error. The flash may be left mid-sequence; the next command proceeds normally and no recovery sequence is inserted.
- CmdValid held through DONE: a new accept occurs in IDLE the cycle after Done, so back-to-back commands are 1 idle cycle apart.

Decomposition:
- Package flash_seq_pkg holds:
  - CmdOp encodings.
  - State enum.
  - Command constants: 5555, 2AAA, AA, 55, A0, 80, 30, 10, 90, F0.
  - Per-op step ROM as a function returning {is_read, addr_sel, data_sel, last}.
- One sub-module, flash_bus_cycle: the SETUP/PULSE/HOLD timer for a single read or write.
  - Inputs: start, is_read.
  - Outputs: WEbar, REbar, sample, cyc_done.
  - The top level sequences steps and polling.

Test Plan:
- Reset then READ at 0x1234, flash model returns 0x5A -> one read cycle, REbar low 2 cycles, Done 5 cycles after accept, RdData=0x005A, Error=0.
- PROGRAM 0x0100/0x3C; model toggles DQ6 for 3 reads, then stable -> bus trace 5555/AA, 2AAA/55, 5555/A0, 0100/3C, each WEbar low exactly 2 cycles; polling stops on first equal pair; Done with Error=0.
- SECTOR_ERASE 0x2000, DQ6 toggles forever, POLL_MAX=4 -> six writes ending 2000/30, 4 poll pairs, then Done with Error=1.
- READ_ID, model mfr=0xBF dev=0xD7 -> RdData=0xD7BF, final write 5555/F0, FDataOE=0 during both reads.
- RST asserted during the 2nd write of CHIP_ERASE -> next edge WEbar=ENbar=1, FDataOE=0, CmdReady=1; subsequent READ completes correctly.
- CmdOp=6, then CmdValid held for two commands -> Error=1 with no ENbar activity; second accept occurs exactly 1 cycle after the first Done.
